// File: rtl/gpr_file_sb.sv
// gpr_file_sb
// Two-read / two-write general-purpose register file with a per-register
// pending scoreboard used by decode to stall on in-flight destinations.
// Register 0 always reads as zero, always reads valid and never becomes pending.
// Optional build macro: GPR_BYPASS_EN
//   defined   : read ports forward same-cycle write data with rv forced high
//   undefined : reads see array contents and pending state only
module gpr_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rv1,
    output logic              rv2,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              bs_en,
    input  logic [ADDR_W-1:0] bs_addr,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    // Architectural state
    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [CNT_W-1:0]  r_pend_cnt;

    // Per-register decode of this cycle's write / busy-set activity
    logic [DEPTH-1:0]  w_wr0;
    logic [DEPTH-1:0]  w_wr1;
    logic [DEPTH-1:0]  w_set;
    logic [DEPTH-1:0]  w_clr;
    logic [DEPTH-1:0]  w_pend_next;
    logic [CNT_W-1:0]  w_cnt_next;

    genvar gi;

    // Address decode. Entry 0 never decodes, so writes, busy-sets and
    // pending state for register 0 are structurally impossible.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_dec
            if (gi == 0) begin : g_zero
                assign w_wr0[gi]       = 1'b0;
                assign w_wr1[gi]       = 1'b0;
                assign w_set[gi]       = 1'b0;
                assign w_clr[gi]       = 1'b0;
                assign w_pend_next[gi] = 1'b0;
            end else begin : g_reg
                assign w_wr0[gi] = we0   && (wa0     == ADDR_W'(gi));
                assign w_wr1[gi] = we1   && (wa1     == ADDR_W'(gi));
                assign w_set[gi] = bs_en && (bs_addr == ADDR_W'(gi));
                // Both write ports hitting one register clear it only once:
                // clearing is a level, not a decrement.
                assign w_clr[gi] = w_wr0[gi] || w_wr1[gi];
                // A new producer issuing this cycle supersedes the retiring write.
                assign w_pend_next[gi] = w_set[gi] || (r_pend[gi] && !w_clr[gi]);
            end
        end
    endgenerate

    // Pending count is the population count of the next pending vector, so it
    // always matches the scoreboard exactly and cannot wrap or underflow.
    always_comb begin
        w_cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_next = w_cnt_next + CNT_W'(w_pend_next[i]);
        end
    end

    // Register array, scoreboard and count; port 1 (younger) wins on a write collision
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (w_wr1[i]) begin
                    r_regs[i] <= wd1;
                end else if (w_wr0[i]) begin
                    r_regs[i] <= wd0;
                end
            end
            r_pend     <= w_pend_next;
            r_pend_cnt <= w_cnt_next;
        end
    end

    assign pend_cnt = r_pend_cnt;

    // Read ports: identical combinational paths, one instance per port
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_ra;
            logic [DATA_W-1:0] w_rd;
            logic              w_rv;

            assign w_ra = (gi == 0) ? ra1 : ra2;

            // Array lookup, register-0 override and optional write forwarding
            always_comb begin
                w_rd = r_regs[w_ra];
                w_rv = !r_pend[w_ra];
                if (w_ra == '0) begin
                    w_rd = '0;
                    w_rv = 1'b1;
                end
`ifdef GPR_BYPASS_EN
                // Forwarded data is by definition produced, so it reads valid
                // even if a new producer is being marked in the same cycle.
                else if (we1 && (wa1 == w_ra)) begin
                    w_rd = wd1;
                    w_rv = 1'b1;
                end else if (we0 && (wa0 == w_ra)) begin
                    w_rd = wd0;
                    w_rv = 1'b1;
                end
`endif
            end
        end
    endgenerate

    assign rd1 = g_rd[0].w_rd;
    assign rv1 = g_rd[0].w_rv;
    assign rd2 = g_rd[1].w_rd;
    assign rv2 = g_rd[1].w_rv;

endmodule

// File: tb/tb_gpr_file_sb.sv
// Directed bench for gpr_file_sb (DATA_W=32, ADDR_W=5).
// Expectations are hand-computed; same-cycle read expectations depend on GPR_BYPASS_EN.
module tb_gpr_file_sb;

    logic        clk;
    logic        reset;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        rv1, rv2;
    logic        we0, we1;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        bs_en;
    logic [4:0]  bs_addr;
    logic [5:0]  pend_cnt;

    int checks = 0;
    int passed = 0;

`ifdef GPR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    gpr_file_sb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .rv1      (rv1),
        .rv2      (rv2),
        .we0      (we0),
        .wa0      (wa0),
        .wd0      (wd0),
        .we1      (we1),
        .wa1      (wa1),
        .wd1      (wd1),
        .bs_en    (bs_en),
        .bs_addr  (bs_addr),
        .pend_cnt (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
            $display("check %-14s obs=%0h exp=%0h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        bs_en = 1'b0; bs_addr = '0;
    endtask

    initial begin
        // Reset with a write presented: nothing may land
        idle_inputs();
        reset = 1'b0;
        ra1 = 5'd3; ra2 = 5'd0;
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEADBEEF;
        tick(); tick();
        chk("rst_rd1", rd1, 32'h0);
        chk("rst_rv1", rv1, 1'b1);
        chk("rst_rd2", rd2, 32'h0);
        chk("rst_rv2", rv2, 1'b1);
        chk("rst_cnt", pend_cnt, 6'd0);
        we0 = 1'b0;
        reset = 1'b1;
        tick();
        chk("post_rst_rd1", rd1, 32'h0);
        chk("post_rst_cnt", pend_cnt, 6'd0);

        // Dual write to the same address: port 1 wins
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
        ra1 = 5'd7;
        #1;
        chk("dual_pre", rd1, BYP ? 32'h22 : 32'h0);
        tick();
        idle_inputs();
        chk("dual_rd1", rd1, 32'h22);
        chk("dual_rv1", rv1, 1'b1);

        // Write to register 0 is ignored
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h55;
        ra1 = 5'd0;
        tick();
        idle_inputs();
        chk("r0_rd1", rd1, 32'h0);
        chk("r0_rv1", rv1, 1'b1);

        // Independent writes on both ports
        we0 = 1'b1; wa0 = 5'd10; wd0 = 32'hA0;
        we1 = 1'b1; wa1 = 5'd11; wd1 = 32'hB1;
        tick();
        idle_inputs();
        ra1 = 5'd10; ra2 = 5'd11;
        #1;
        chk("two_wr_rd1", rd1, 32'hA0);
        chk("two_wr_rd2", rd2, 32'hB1);

        // Scoreboard: mark r5 then r6
        bs_en = 1'b1; bs_addr = 5'd5;
        ra1 = 5'd5; ra2 = 5'd6;
        #1;
        chk("bs5_pre_rv1", rv1, 1'b1);
        tick();
        chk("bs5_cnt", pend_cnt, 6'd1);
        chk("bs5_rv1", rv1, 1'b0);
        bs_addr = 5'd6;
        tick();
        idle_inputs();
        chk("bs6_cnt", pend_cnt, 6'd2);
        chk("bs6_rv1", rv1, 1'b0);
        chk("bs6_rv2", rv2, 1'b0);

        // Writeback to r5 retires it
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h5A;
        tick();
        idle_inputs();
        chk("wb5_rv1", rv1, 1'b1);
        chk("wb5_rd1", rd1, 32'h5A);
        chk("wb5_cnt", pend_cnt, 6'd1);

        // Set and clear r6 together: set wins, data still written
        bs_en = 1'b1; bs_addr = 5'd6;
        we1 = 1'b1; wa1 = 5'd6; wd1 = 32'h99;
        #1;
        chk("sc6_pre_rv2", rv2, BYP ? 1'b1 : 1'b0);
        chk("sc6_pre_rd2", rd2, BYP ? 32'h99 : 32'h0);
        tick();
        idle_inputs();
        chk("sc6_rv2", rv2, 1'b0);
        chk("sc6_rd2", rd2, 32'h99);
        chk("sc6_cnt", pend_cnt, 6'd1);

        // Busy-set on register 0 is ignored
        bs_en = 1'b1; bs_addr = 5'd0;
        ra1 = 5'd0;
        tick();
        idle_inputs();
        chk("bs0_cnt", pend_cnt, 6'd1);
        chk("bs0_rv1", rv1, 1'b1);

        // Repeated busy-set on r9 counts once
        bs_en = 1'b1; bs_addr = 5'd9;
        ra1 = 5'd9;
        tick(); tick(); tick();
        idle_inputs();
        chk("bs9_cnt", pend_cnt, 6'd2);
        chk("bs9_rv1", rv1, 1'b0);

        // Clearing a non-pending register: write lands, count unchanged
        we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h12;
        ra1 = 5'd12;
        tick();
        idle_inputs();
        chk("np12_rd1", rd1, 32'h12);
        chk("np12_cnt", pend_cnt, 6'd2);

        // Two pending registers retired in one edge
        we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h66;
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h9;
        tick();
        idle_inputs();
        chk("clr2_cnt", pend_cnt, 6'd0);

        // Same-cycle forwarding on port 2 to a pending register
        bs_en = 1'b1; bs_addr = 5'd4;
        ra2 = 5'd4;
        tick();
        idle_inputs();
        chk("byp_pend_rv2", rv2, 1'b0);
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'hCAFE;
        #1;
        chk("byp_pre_rd2", rd2, BYP ? 32'hCAFE : 32'h0);
        chk("byp_pre_rv2", rv2, BYP ? 1'b1 : 1'b0);
        tick();
        idle_inputs();
        chk("byp_post_rd2", rd2, 32'hCAFE);
        chk("byp_post_rv2", rv2, 1'b1);
        chk("byp_post_cnt", pend_cnt, 6'd0);

        // Fill the scoreboard r1..r31
        for (int i = 1; i <= 31; i++) begin
            bs_en = 1'b1; bs_addr = 5'(i);
            tick();
            chk($sformatf("fill_cnt_%0d", i), pend_cnt, 64'(i));
        end
        idle_inputs();
        ra1 = 5'd31; ra2 = 5'd0;
        #1;
        chk("full_rv1", rv1, 1'b0);
        chk("full_rv2", rv2, 1'b1);

        // Drain with alternating ports, two registers per edge
        for (int i = 1; i <= 31; i += 2) begin
            we0 = 1'b1; wa0 = 5'(i); wd0 = 32'(i);
            we1 = (i + 1 <= 31); wa1 = 5'(i + 1); wd1 = 32'(i + 1);
            tick();
            chk($sformatf("drain_cnt_%0d", i), pend_cnt, 64'((i + 1 <= 31) ? 31 - (i + 1) : 0));
        end
        idle_inputs();
        we0 = 1'b1; wa0 = 5'd1; wd0 = 32'h1;
        we1 = 1'b1; wa1 = 5'd1; wd1 = 32'h101;
        tick();
        idle_inputs();
        ra1 = 5'd1; ra2 = 5'd30;
        #1;
        chk("empty_cnt", pend_cnt, 6'd0);
        chk("empty_rd1", rd1, 32'h101);
        chk("empty_rd2", rd2, 32'd30);
        chk("empty_rv2", rv2, 1'b1);

        // Asynchronous reset mid-cycle clears data and scoreboard immediately
        bs_en = 1'b1; bs_addr = 5'd2;
        tick();
        idle_inputs();
        chk("pre_arst_cnt", pend_cnt, 6'd1);
        ra1 = 5'd7;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_cnt", pend_cnt, 6'd0);
        chk("arst_rd1", rd1, 32'h0);
        chk("arst_rd2", rd2, 32'h0);
        tick();
        reset = 1'b1;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/gpr_file_sb.md
# gpr_file_sb

Parametrised general-purpose register file with two read ports, two write ports and a per-register pending scoreboard. It sits in the decode/writeback path of the pipelined core. It replaces the single-write-port GPR with:
- a configurable data width and depth;
- deterministic dual-write arbitration;
- valid flags that let decode stall on registers whose producer has not yet written back;
- optional same-cycle write-to-read forwarding.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth is 2**ADDR_W registers, register 0 hardwired to zero

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset; clears all registers and pending bits
- ra1  in  ADDR_W  read address, port 1
- ra2  in  ADDR_W  read address, port 2
- rd1  out  DATA_W  read data, port 1 (combinational)
- rd2  out  DATA_W  read data, port 2 (combinational)
- rv1  out  1  port-1 data valid (register not pending)
- rv2  out  1  port-2 data valid
- we0  in  1  write enable, port 0 (older writeback)
- wa0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (younger writeback)
- wa1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- bs_en  in  1  mark register busy (instruction issued with destination bs_addr)
- bs_addr  in  ADDR_W  destination being marked pending
- pend_cnt  out  ADDR_W+1  number of registers currently pending

## Operation
- State: array reg[0..2**ADDR_W-1] of DATA_W bits; pending bit vector pend[]; counter pend_cnt.
- Reads: rd = reg[ra], rv = !pend[ra]. Address 0 always gives rd=0 and rv=1.
- Writes: on clk rise, if weN and waN!=0, then reg[waN] <= wdN and pend[waN] is cleared.
  - we0 and we1 to the same nonzero address in one cycle: port 1 data wins; pending is cleared once.
- Busy set: on clk rise, if bs_en and bs_addr!=0, then pend[bs_addr] <= 1.
  - Set and clear to the same address in one cycle: set wins (a new producer supersedes the retiring write). The data write still occurs.
  - Setting an already-pending bit is a no-op.
  - Clearing a non-pending bit is a no-op, and the write still occurs.
- pend_cnt tracks the population count of pend[] exactly, updated in the same edge as pend[]. It never wraps: the maximum is 2**ADDR_W-1 because register 0 is excluded.
- Address 0: writes ignored, busy-set ignored, never pending.

## Timing
- Reset (reset=0, asynchronous assert, deasserted synchronously to clk by the system): all reg=0, all pend=0, pend_cnt=0. rd1/rd2 read 0, rv1/rv2=1.
  - Reset asserted mid-cycle while writes are presented: no write lands.
- Without bypass, write latency is 1 cycle: data written at edge N is visible on rd from just after edge N.
- Pending latency is 1 cycle: bs_en at edge N makes rv drop after edge N. A write at edge M raises rv after edge M.
- No handshake back-pressure: every write and busy-set is accepted unconditionally.

## Configuration
- GPR_BYPASS_EN defined: read ports forward same-cycle write data combinationally.
  - If weK and waK==ra and ra!=0, then rd = wdK and rv = 1.
  - If both write ports match, wd1 is used.
  - A same-cycle bs_en to the same address does not affect that cycle's forwarded rv=1.
- GPR_BYPASS_EN undefined: reads return array contents and pending state only. Zero-latency forwarding is absent, and writes become visible the cycle after.

## Test plan
- Reset: drive reset=0 with we0=1, wa0=3, wd0=0xDEADBEEF → after reset release, ra1=3 gives rd1=0, rv1=1, pend_cnt=0.
- Dual write conflict: we0=we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22 → next cycle rd1(ra1=7)=0x22. A separate cycle with wa0=0, wd0=0x55 → rd(0)=0.
- Scoreboard: bs_en on r5 then r6 → pend_cnt=2, rv(5)=0. Then we0 to r5 → rv(5)=1, pend_cnt=1. Simultaneous bs_en=r6 and we1=r6 with wd1=0x99 → r6 still pending, reg=0x99, pend_cnt=1.
- Busy-set edge cases: bs_en with bs_addr=0 → pend_cnt unchanged. Repeated bs_en on r9 for 3 cycles → pend_cnt increments by exactly 1.
- Bypass (GPR_BYPASS_EN defined): ra2=4 with we1=1, wa1=4, wd1=0xCAFE in the same cycle → rd2=0xCAFE, rv2=1 before the edge. Same stimulus with the macro undefined → rd2 shows the old value until after the edge.
- Full scoreboard: bs_en on r1..r31 (ADDR_W=5) → pend_cnt=31. Then clear all with alternating we0/we1 → pend_cnt returns to 0 with no underflow.
